// File: rtl/panda_risc_v_inst_buf.sv
// Fetch-result buffer between the fetch unit and decode: a first-word-fall-through
// circular queue of {user, data} entries with a one-cycle flush.
module panda_risc_v_inst_buf #(
    parameter int inst_buf_depth   = 4,
    parameter int simulation_delay = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush_req,
    input  logic [127:0] s_axis_if_res_data,
    input  logic [3:0]   s_axis_if_res_user,
    input  logic         s_axis_if_res_valid,
    output logic         s_axis_if_res_ready,
    output logic [127:0] m_axis_inst_data,
    output logic [3:0]   m_axis_inst_user,
    output logic         m_axis_inst_valid,
    input  logic         m_axis_inst_ready,
    output logic [4:0]   inst_buf_cnt,
    output logic         inst_buf_empty,
    output logic         inst_buf_full
);

    localparam int PTR_W = $clog2(inst_buf_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 132;

    // Register updates carry no delay in RTL; the delay value only has to be sane.
    if ((inst_buf_depth < 2) || (inst_buf_depth > 16) ||
        ((inst_buf_depth & (inst_buf_depth - 1)) != 0) || (simulation_delay < 0)) begin : g_bad_param
        $error("panda_risc_v_inst_buf: illegal parameter value");
    end

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ENT_W-1:0] mem_q [inst_buf_depth];
    logic [ENT_W-1:0] mem_d [inst_buf_depth];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (cnt_q == CNT_W'(inst_buf_depth));
    assign empty = (cnt_q == '0);

    // Ready depends only on occupancy, so the two AXIS sides never connect combinationally.
    assign s_axis_if_res_ready = ~full;
    assign m_axis_inst_valid   = ~empty;
    assign m_axis_inst_data    = mem_q[rptr_q][127:0];
    assign m_axis_inst_user    = mem_q[rptr_q][131:128];
    assign inst_buf_cnt        = 5'(cnt_q);
    assign inst_buf_empty      = empty;
    assign inst_buf_full       = full;

    assign push = s_axis_if_res_valid & ~full & ~flush_req;
    assign pop  = ~empty & m_axis_inst_ready & ~flush_req;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        mem_d  = mem_q;
        if (flush_req) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = {s_axis_if_res_user, s_axis_if_res_data};
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry contents are never reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_panda_risc_v_inst_buf.sv
// Bench for panda_risc_v_inst_buf: queue-based reference model checked every
// negative edge, plus directed scenarios with literal expectations.
module tb_panda_risc_v_inst_buf;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         flush_req = 1'b0;
    logic [127:0] s_data = '0;
    logic [3:0]   s_user = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] m_data;
    logic [3:0]   m_user;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [4:0]   cnt;
    logic         empty;
    logic         full;

    panda_risc_v_inst_buf #(
        .inst_buf_depth  (DEPTH),
        .simulation_delay(1)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .flush_req          (flush_req),
        .s_axis_if_res_data (s_data),
        .s_axis_if_res_user (s_user),
        .s_axis_if_res_valid(s_valid),
        .s_axis_if_res_ready(s_ready),
        .m_axis_inst_data   (m_data),
        .m_axis_inst_user   (m_user),
        .m_axis_inst_valid  (m_valid),
        .m_axis_inst_ready  (m_ready),
        .inst_buf_cnt       (cnt),
        .inst_buf_empty     (empty),
        .inst_buf_full      (full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [131:0] model_q [$];
    logic [31:0]  out_pc [$];
    logic [3:0]   out_user [$];
    bit           m_push;
    bit           m_pop;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] pc);
        return {32'h0, ~pc, pc, 32'h0000_0013};
    endfunction

    // Reference model: plain queue, flush wins, push only when not full.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            model_q.delete();
        end else begin
            m_pop  = (model_q.size() > 0) && m_ready && !flush_req;
            m_push = s_valid && (model_q.size() < DEPTH) && !flush_req;
            if (flush_req) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) model_q.push_back({s_user, s_data});
            end
        end
    end

    always @(negedge clk) begin
        check("ready", 132'(s_ready), 132'(model_q.size() < DEPTH));
        check("valid", 132'(m_valid), 132'(model_q.size() > 0));
        check("cnt", 132'(cnt), 132'(model_q.size()));
        check("empty", 132'(empty), 132'(model_q.size() == 0));
        check("full", 132'(full), 132'(model_q.size() == DEPTH));
        if (model_q.size() > 0) check("head", {m_user, m_data}, model_q[0]);
        if (resetn && m_valid && m_ready && !flush_req) begin
            out_pc.push_back(m_data[63:32]);
            out_user.push_back(m_user);
        end
    end

    task automatic beat(input bit v, input logic [31:0] pc, input logic [3:0] u,
                        input bit r, input bit f);
        s_valid   = v;
        s_data    = mk(pc);
        s_user    = u;
        m_ready   = r;
        flush_req = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc [5];

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 132'(m_valid), 132'(0));
        check("rst_ready", 132'(s_ready), 132'(1));
        check("rst_cnt", 132'(cnt), 132'(0));
        check("rst_empty", 132'(empty), 132'(1));
        check("rst_full", 132'(full), 132'(0));
        resetn = 1'b1;

        // Fill with downstream stalled, then drain in order
        for (int i = 0; i < 4; i++) beat(1'b1, 32'(4 * i), 4'h0, 1'b0, 1'b0);
        check("fill_cnt", 132'(cnt), 132'(4));
        check("fill_ready", 132'(s_ready), 132'(0));
        check("fill_full", 132'(full), 132'(1));
        check("fill_head_pc", 132'(m_data[63:32]), 132'(32'h0));
        out_pc.delete();
        out_user.delete();
        for (int i = 0; i < 4; i++) beat(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("drain_n", 132'(out_pc.size()), 132'(4));
        for (int i = 0; i < 4; i++)
            if (i < out_pc.size()) check("drain_pc", 132'(out_pc[i]), 132'(32'(4 * i)));
        check("drain_cnt", 132'(cnt), 132'(0));

        // Streaming through a wrapping queue
        out_pc.delete();
        out_user.delete();
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, 32'h1000 + 32'(4 * i), 4'(i), 1'b1, 1'b0);
            check("stream_cnt", 132'(cnt), 132'(1));
        end
        beat(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("stream_n", 132'(out_pc.size()), 132'(20));
        for (int i = 0; i < 20; i++)
            if (i < out_pc.size()) check("stream_pc", 132'(out_pc[i]), 132'(32'h1000 + 32'(4 * i)));
        check("stream_cnt_end", 132'(cnt), 132'(0));

        // Flush with 3 entries, concurrent push and pop
        for (int i = 0; i < 3; i++) beat(1'b1, 32'h10 + 32'(4 * i), 4'h0, 1'b0, 1'b0);
        check("pre_flush_cnt", 132'(cnt), 132'(3));
        out_pc.delete();
        out_user.delete();
        beat(1'b1, 32'h100, 4'h0, 1'b1, 1'b1);
        check("flush_cnt", 132'(cnt), 132'(0));
        check("flush_valid", 132'(m_valid), 132'(0));
        beat(1'b1, 32'h200, 4'h0, 1'b0, 1'b0);
        check("post_flush_valid", 132'(m_valid), 132'(1));
        check("post_flush_head", 132'(m_data[63:32]), 132'(32'h200));
        check("post_flush_cnt", 132'(cnt), 132'(1));
        beat(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("post_flush_n", 132'(out_pc.size()), 132'(1));
        if (out_pc.size() > 0) check("post_flush_pc", 132'(out_pc[0]), 132'(32'h200));

        // Full with pop and held push; user side-band pass-through
        out_pc.delete();
        out_user.delete();
        beat(1'b1, 32'h300, 4'b1010, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) beat(1'b1, 32'h300 + 32'(4 * i), 4'h0, 1'b0, 1'b0);
        check("full2_full", 132'(full), 132'(1));
        check("full2_ready", 132'(s_ready), 132'(0));
        check("full2_head_user", 132'(m_user), 132'(4'b1010));
        beat(1'b1, 32'h310, 4'h0, 1'b1, 1'b0);
        check("full_pop_cnt", 132'(cnt), 132'(3));
        check("full_pop_ready", 132'(s_ready), 132'(1));
        beat(1'b1, 32'h310, 4'h0, 1'b0, 1'b0);
        check("refill_cnt", 132'(cnt), 132'(4));
        for (int i = 0; i < 4; i++) beat(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        exp_pc = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310};
        check("full2_n", 132'(out_pc.size()), 132'(5));
        for (int i = 0; i < 5; i++)
            if (i < out_pc.size()) check("full2_pc", 132'(out_pc[i]), 132'(exp_pc[i]));
        if (out_user.size() > 0) check("user_pass", 132'(out_user[0]), 132'(4'b1010));

        // Asynchronous reset between edges
        beat(1'b1, 32'h400, 4'h0, 1'b0, 1'b0);
        beat(1'b1, 32'h404, 4'h0, 1'b0, 1'b0);
        check("pre_arst_cnt", 132'(cnt), 132'(2));
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", 132'(m_valid), 132'(0));
        check("arst_cnt", 132'(cnt), 132'(0));
        check("arst_ready", 132'(s_ready), 132'(1));
        check("arst_empty", 132'(empty), 132'(1));
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        beat(1'b1, 32'h500, 4'h3, 1'b0, 1'b0);
        check("post_arst_head", 132'(m_data[63:32]), 132'(32'h500));
        check("post_arst_cnt", 132'(cnt), 132'(1));
        beat(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
